ahb2apb_bridge_mslave: RTL
==========================

Name: ahb2apb_bridge_mslave

Overview:
Parametrised AHB-lite slave to APB4 master bridge. It is the successor to the current fixed three-slave bridge, generalised in address/data width and slave count. New over the current bridge: PREADY wait states, PSLVERR-to-HRESP error mapping, PSTRB generation, illegal-size and out-of-range decode errors, and an optional PREADY timeout. It sits between the AHB interconnect and NUM_SLAVES APB peripherals.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64)
NUM_SLAVES, 3, number of APB slaves / Pselx bits
BASE_ADDR, 32'h8000_0000, base of slave 0 region
REGION_BITS, 12, log2 of region size; slave i decodes BASE_ADDR + i*2^REGION_BITS
TIMEOUT, 0, ACCESS cycles without Pready before forced error; 0 = disabled

Ports:
Hclk  in  1  clock
Hreset  in  1  asynchronous active-high reset
Haddr  in  ADDR_W  AHB address
Htrans  in  2  AHB transfer type
Hwrite  in  1  AHB write
Hsize  in  3  AHB size
Hwdata  in  DATA_W  AHB write data
Hreadyin  in  1  bus HREADY
Hreadyout  out  1  slave ready
Hresp  out  1  0=OKAY, 1=ERROR
Hrdata  out  DATA_W  read data
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Pwrite  out  1  APB write
Pstrb  out  DATA_W/8  APB4 byte strobes
Pselx  out  NUM_SLAVES  one-hot select
Penable  out  1  APB enable
Prdata  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
Pready  in  NUM_SLAVES  per-slave ready
Pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async, any state): state=IDLE, Paddr/Pwdata/Pwrite/Pstrb/index/timer=0. Outputs: Hreadyout=1, Hresp=0, Hrdata=0, Pselx=0, Penable=0.
- Accept condition: Hreadyin & Htrans[1] (NONSEQ or SEQ), while in IDLE, ERR2, or the completing ACCESS cycle (back-to-back). IDLE/BUSY transfers are ignored, with zero-wait OKAY.
- On accept, latch Haddr, Hwrite, Hsize, and index=(Haddr-BASE_ADDR)>>REGION_BITS.
- Decode error: index>=NUM_SLAVES, Haddr<BASE_ADDR, or Hsize>log2(DATA_W/8). Goes to ERR1; no APB access is issued.
- States:
  - IDLE.
  - WWAIT (write only): Hreadyout=0; Hwdata is latched into Pwdata at end of cycle; -> SETUP.
  - SETUP: Pselx[index]=1, Penable=0, Hreadyout=0; -> ACCESS.
  - ACCESS: Pselx[index]=1, Penable=1.
  - ERR1: Hresp=1, Hreadyout=0; -> ERR2.
  - ERR2: Hresp=1, Hreadyout=1; accepts like IDLE, else -> IDLE.
- Read accept: goes directly to SETUP.
- ACCESS, Pready[index]=0: stay; timer increments.
- ACCESS, Pready[index]=1 & Pslverr=0: Hreadyout=1. For reads, Hrdata=Prdata slice combinationally this cycle (0 otherwise). Then next state per accept condition, else IDLE.
- ACCESS, Pready[index]=1 & Pslverr=1: Hreadyout=0, -> ERR1. Hrdata=0.
- Timeout (TIMEOUT>0): timer==TIMEOUT-1 with Pready low -> Pselx/Penable drop, -> ERR1. The timer clears on entry to SETUP.
- Pstrb: reads are all zero. Writes: (2^(2^Hsize))-1 shifted left by Haddr[log2(DATA_W/8)-1:0] aligned down to size.
- Paddr: held stable from SETUP through ACCESS end. Pwrite and Pstrb are likewise stable.
- Latency: read with zero-wait slave = 2 wait cycles (SETUP, ACCESS). Write = 2 wait cycles (WWAIT, SETUP); the ACCESS cycle completes it.
- Pselx is always one-hot or zero. Penable=1 only in ACCESS.

Test Plan:
- Reset mid-ACCESS (Hreset pulsed while Pselx=3'b010, Penable=1) -> next edge: Pselx=0, Penable=0, Hreadyout=1, Hresp=0.
- Write Haddr=32'h8000_1004, Hsize=2, Hwdata=32'hDEAD_BEEF, Pready=1 -> WWAIT, then SETUP with Pselx=3'b010, Paddr=32'h8000_1004, Pwdata=32'hDEAD_BEEF, Pstrb=4'hF, Pwrite=1; Penable=1 next cycle; Hreadyout=1 in ACCESS.
- Read Haddr=32'h8000_2000, Prdata slave2=32'h1234_5678, Pready[2] low 3 cycles -> Hreadyout=0 for SETUP+3 cycles, then Hrdata=32'h1234_5678 with Hreadyout=1.
- Byte write Haddr=32'h8000_0003, Hsize=0 -> Pstrb=4'b1000. Halfword at 32'h8000_0002 -> Pstrb=4'b1100.
- Pslverr[0]=1 with Pready[0]=1 -> ERR1 (Hresp=1, Hreadyout=0), ERR2 (Hresp=1, Hreadyout=1). Haddr=32'h8000_3000 (index 3) -> same two-cycle error, Pselx stays 0.
- TIMEOUT=4, Pready stuck low -> exactly 4 ACCESS cycles, then Pselx=0 and the ERROR response. Back-to-back reads to slaves 0 then 1 -> second SETUP directly follows first ACCESS completion.

Source files
------------

// File: rtl/ahb2apb_bridge_mslave_if.sv
// Signal bundle between the AHB-lite interconnect, the bridge and its APB4 peripherals.
// The slave modport is the bridge's view; the master modport is the surrounding bus/peripheral view.
interface ahb2apb_bridge_mslave_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 3
);
    logic [ADDR_W-1:0]            Haddr;
    logic [1:0]                   Htrans;
    logic                         Hwrite;
    logic [2:0]                   Hsize;
    logic [DATA_W-1:0]            Hwdata;
    logic                         Hreadyin;
    logic                         Hreadyout;
    logic                         Hresp;
    logic [DATA_W-1:0]            Hrdata;
    logic [ADDR_W-1:0]            Paddr;
    logic [DATA_W-1:0]            Pwdata;
    logic                         Pwrite;
    logic [DATA_W/8-1:0]          Pstrb;
    logic [NUM_SLAVES-1:0]        Pselx;
    logic                         Penable;
    logic [NUM_SLAVES*DATA_W-1:0] Prdata;
    logic [NUM_SLAVES-1:0]        Pready;
    logic [NUM_SLAVES-1:0]        Pslverr;

    modport slave (
        input  Haddr, Htrans, Hwrite, Hsize, Hwdata, Hreadyin,
        input  Prdata, Pready, Pslverr,
        output Hreadyout, Hresp, Hrdata,
        output Paddr, Pwdata, Pwrite, Pstrb, Pselx, Penable
    );

    modport master (
        output Haddr, Htrans, Hwrite, Hsize, Hwdata, Hreadyin,
        output Prdata, Pready, Pslverr,
        input  Hreadyout, Hresp, Hrdata,
        input  Paddr, Pwdata, Pwrite, Pstrb, Pselx, Penable
    );
endinterface

// File: rtl/ahb2apb_bridge_mslave.sv
// AHB-lite slave to APB4 master bridge for NUM_SLAVES equally sized regions above BASE_ADDR,
// with PREADY wait states, PSLVERR/decode errors mapped to a two-cycle AHB ERROR and an optional PREADY timeout.
module ahb2apb_bridge_mslave #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLAVES  = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int                REGION_BITS = 12,
    parameter int                TIMEOUT     = 0
) (
    input  logic                         Hclk,
    input  logic                         Hreset,
    ahb2apb_bridge_mslave_if.slave       bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMR_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]       SIZE_MAX = 3'(LANE_W);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic             TMO_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    // A lane is strobed when it falls in the same size-aligned block as the transfer address.
    function automatic logic [STRB_W-1:0] strb_calc(input logic [LANE_W-1:0] lane_lo,
                                                    input logic [2:0]        size);
        logic [STRB_W-1:0] strb;
        strb = '0;
        for (int b = 0; b < STRB_W; b++) begin
            strb[b] = ((b >> size) == (int'(lane_lo) >> size));
        end
        return strb;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [ADDR_W-1:0]     paddr_r;
    logic [DATA_W-1:0]     pwdata_r;
    logic                  pwrite_r;
    logic [STRB_W-1:0]     pstrb_r;
    logic [IDX_W-1:0]      index_r;
    logic [TMR_W-1:0]      timer_r;

    logic [ADDR_W-1:0]     region_s;
    logic                  dec_err_s;
    logic                  accept_s;
    logic                  done_ok_s;
    logic                  timeout_s;
    logic                  take_s;
    logic [NUM_SLAVES-1:0] sel_s;
    logic                  pready_sel_s;
    logic                  pslverr_sel_s;
    logic [DATA_W-1:0]     prdata_sel_s;

    logic                  hready_s;
    logic                  hresp_s;
    logic [DATA_W-1:0]     hrdata_s;
    logic [NUM_SLAVES-1:0] psel_s;
    logic                  penable_s;

    // Address decode of the incoming AHB address phase.
    always_comb begin
        region_s  = (bus.Haddr - BASE_ADDR) >> REGION_BITS;
        dec_err_s = (bus.Haddr < BASE_ADDR) ||
                    (region_s >= ADDR_W'(NUM_SLAVES)) ||
                    (bus.Hsize > SIZE_MAX);
    end

    // Route the latched slave's ready/error/read data back to the bridge.
    always_comb begin
        pready_sel_s  = 1'b0;
        pslverr_sel_s = 1'b0;
        prdata_sel_s  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_s[i]     = (index_r == IDX_W'(i));
            prdata_sel_s = prdata_sel_s | (bus.Prdata[i*DATA_W +: DATA_W] & {DATA_W{sel_s[i]}});
        end
        pready_sel_s  = |(bus.Pready & sel_s);
        pslverr_sel_s = |(bus.Pslverr & sel_s);
    end

    // Transfer acceptance, completion and timeout qualifiers.
    always_comb begin
        accept_s  = bus.Hreadyin && ((bus.Htrans == 2'b10) || (bus.Htrans == 2'b11));
        done_ok_s = (state_r == ST_ACCESS) && pready_sel_s && !pslverr_sel_s;
        timeout_s = TMO_EN && (state_r == ST_ACCESS) && !pready_sel_s && (timer_r == TMR_LAST);
        take_s    = accept_s && ((state_r == ST_IDLE) || (state_r == ST_ERR2) || done_ok_s);
    end

    // State register.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a new transfer can be taken wherever the bus sees Hreadyout high.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (take_s) begin
                    state_next_s = dec_err_s ? ST_ERR1 : (bus.Hwrite ? ST_WWAIT : ST_SETUP);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WWAIT:  state_next_s = ST_SETUP;
            ST_SETUP:  state_next_s = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_sel_s && pslverr_sel_s) begin
                    state_next_s = ST_ERR1;
                end else if (done_ok_s && take_s) begin
                    state_next_s = dec_err_s ? ST_ERR1 : (bus.Hwrite ? ST_WWAIT : ST_SETUP);
                end else if (done_ok_s) begin
                    state_next_s = ST_IDLE;
                end else if (timeout_s) begin
                    state_next_s = ST_ERR1;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_ERR1:   state_next_s = ST_ERR2;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the current state and the selected slave's response.
    always_comb begin
        hready_s  = 1'b1;
        hresp_s   = 1'b0;
        hrdata_s  = '0;
        psel_s    = '0;
        penable_s = 1'b0;
        case (state_r)
            ST_IDLE:  hready_s = 1'b1;
            ST_WWAIT: hready_s = 1'b0;
            ST_SETUP: begin
                hready_s = 1'b0;
                psel_s   = sel_s;
            end
            ST_ACCESS: begin
                psel_s    = sel_s;
                penable_s = 1'b1;
                if (done_ok_s) begin
                    hready_s = 1'b1;
                    hrdata_s = pwrite_r ? '0 : prdata_sel_s;
                end else begin
                    hready_s = 1'b0;
                end
            end
            ST_ERR1: begin
                hresp_s  = 1'b1;
                hready_s = 1'b0;
            end
            ST_ERR2: begin
                hresp_s  = 1'b1;
                hready_s = 1'b1;
            end
            default: hready_s = 1'b1;
        endcase
    end

    // APB address-phase registers, captured on accept and held until the next accept.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            paddr_r  <= '0;
            pwrite_r <= 1'b0;
            pstrb_r  <= '0;
            index_r  <= '0;
            pwdata_r <= '0;
        end else begin
            if (take_s) begin
                paddr_r  <= bus.Haddr;
                pwrite_r <= bus.Hwrite;
                pstrb_r  <= bus.Hwrite ? strb_calc(bus.Haddr[LANE_W-1:0], bus.Hsize) : '0;
                index_r  <= region_s[IDX_W-1:0];
            end
            if (state_r == ST_WWAIT) begin
                pwdata_r <= bus.Hwdata;
            end
        end
    end

    // PREADY wait counter; restarts for every APB transfer.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            timer_r <= '0;
        end else if (state_next_s == ST_SETUP) begin
            timer_r <= '0;
        end else if ((state_r == ST_ACCESS) && !pready_sel_s) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    assign bus.Hreadyout = hready_s;
    assign bus.Hresp     = hresp_s;
    assign bus.Hrdata    = hrdata_s;
    assign bus.Pselx     = psel_s;
    assign bus.Penable   = penable_s;
    assign bus.Paddr     = paddr_r;
    assign bus.Pwdata    = pwdata_r;
    assign bus.Pwrite    = pwrite_r;
    assign bus.Pstrb     = pstrb_r;

endmodule
